// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
// Lock supervisor and reset sequencer for a multi-output PLL. Holds the PLL in
// reset for a fixed time, waits for a stable synchronised lock, then releases
// the downstream domain resets one at a time. A lock loss after release
// re-arms the PLL and is counted. A lock that never settles times out and the
// sequence retries. Runs entirely on the PLL reference clock.

module pll_lock_supervisor #(
  parameter int N_DOMAINS          = 3,
  parameter int PLL_RST_CYCLES     = 32,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int CNT_W              = 8
) (
  input  logic                 refclk,
  input  logic                 rst_n,
  input  logic                 extlock,
  input  logic                 clr_cnt,
  output logic                 pll_reset,
  output logic [N_DOMAINS-1:0] domain_rst_n,
  output logic                 ready,
  output logic [CNT_W-1:0]     lock_loss_cnt,
  output logic                 timeout_err,
  output logic [1:0]           state
);

  // Debug encoding of the sequencer state, visible on the state port.
  localparam logic [1:0] ST_PLL_RST   = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_RELEASE   = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  // Each counter gets one spare bit above its limit, so it cannot wrap
  // before the compare that ends its state fires.
  localparam int REL_SPAN = (N_DOMAINS - 1) * RELEASE_GAP;
  localparam int RST_W    = $clog2(PLL_RST_CYCLES) + 1;
  localparam int STB_W    = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT) + 1;
  localparam int REL_W    = $clog2(REL_SPAN + 1) + 1;

  // Terminal counts. A state ends on the edge where its counter would step
  // past the last value, so each state lasts exactly its parameter in cycles.
  localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(REL_SPAN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  // Synchroniser
  logic sync1_q;
  logic lock_s_q;

  // Sequencer state and per-state counters
  logic [1:0]       state_q,   state_d;
  logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
  logic [STB_W-1:0] stb_cnt_q, stb_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [REL_W-1:0] rel_cnt_q, rel_cnt_d;

  // Registered outputs
  logic                 pll_reset_q,   pll_reset_d;
  logic [N_DOMAINS-1:0] dom_rst_n_q,   dom_rst_n_d;
  logic                 ready_q,       ready_d;
  logic [CNT_W-1:0]     loss_cnt_q,    loss_cnt_d;
  logic                 timeout_err_q, timeout_err_d;

  // Events decoded in the transition logic
  logic lock_lost;
  logic timeout_hit;

  // Two-flop synchroniser for the asynchronous PLL lock. It is cleared by
  // reset, so lock reads as absent until two edges after reset release.
  // NOTE: sequential state uses non-blocking assignments only. Then every
  // flop samples the pre-edge value of the others, and the second stage
  // really lags the first by one edge.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q  <= 1'b0;
      lock_s_q <= 1'b0;
    end else begin
      sync1_q  <= extlock;
      lock_s_q <= sync1_q;
    end
  end

  // Next-state logic. A release in WAIT_LOCK takes priority over the timeout.
  // A lock loss in RELEASE takes priority over moving on to RUN.
  // NOTE: every signal driven here gets a default value first. Otherwise a
  // path that leaves it unassigned would infer a latch.
  always_comb begin
    state_d     = state_q;
    lock_lost   = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      ST_PLL_RST: begin
        if (rst_cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        if (lock_s_q && (stb_cnt_q == STB_LAST)) begin
          state_d = ST_RELEASE;
        end else if (tmo_cnt_q == TMO_LAST) begin
          state_d     = ST_PLL_RST;
          timeout_hit = 1'b1;
        end
      end
      ST_RELEASE: begin
        if (!lock_s_q) begin
          state_d   = ST_PLL_RST;
          lock_lost = 1'b1;
        end else if (rel_cnt_q == REL_LAST) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!lock_s_q) begin
          state_d   = ST_PLL_RST;
          lock_lost = 1'b1;
        end
      end
      default: state_d = ST_PLL_RST;
    endcase
  end

  // Per-state counters. A counter runs only while its state persists and sits
  // at zero otherwise, so every state is entered with a fresh count.
  always_comb begin
    rst_cnt_d = '0;
    stb_cnt_d = '0;
    tmo_cnt_d = '0;
    rel_cnt_d = '0;
    if ((state_q == ST_PLL_RST) && (state_d == ST_PLL_RST)) begin
      rst_cnt_d = rst_cnt_q + 1'b1;
    end
    if ((state_q == ST_WAIT_LOCK) && (state_d == ST_WAIT_LOCK)) begin
      // Any low sample restarts the stability window. Such a glitch is not
      // counted as a lock loss.
      stb_cnt_d = lock_s_q ? (stb_cnt_q + 1'b1) : '0;
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
    if ((state_q == ST_RELEASE) && (state_d == ST_RELEASE)) begin
      rel_cnt_d = rel_cnt_q + 1'b1;
    end
  end

  // Output decode from the next state, so the registered outputs change on
  // the same edge as the state they describe.
  always_comb begin
    pll_reset_d = (state_d == ST_PLL_RST);
    ready_d     = (state_d == ST_RUN);
    dom_rst_n_d = '0;
    if (state_d == ST_RUN) begin
      dom_rst_n_d = '1;
    end else if (state_d == ST_RELEASE) begin
      // Bit k opens once the release counter reaches k*RELEASE_GAP. The
      // counter is zero on the entry edge, so bit 0 opens immediately.
      for (int k = 0; k < N_DOMAINS; k++) begin
        dom_rst_n_d[k] = (int'(rel_cnt_d) >= (k * RELEASE_GAP));
      end
    end
  end

  // Lock-loss counter and timeout flag. A clear coinciding with a loss
  // leaves exactly that one loss counted.
  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (clr_cnt) begin
      loss_cnt_d = lock_lost ? CNT_W'(1) : '0;
    end else if (lock_lost && (loss_cnt_q != CNT_MAX)) begin
      loss_cnt_d = loss_cnt_q + 1'b1;
    end

    timeout_err_d = timeout_err_q;
    if (timeout_hit) begin
      timeout_err_d = 1'b1;
    end else if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
      timeout_err_d = 1'b0;
    end
  end

  // State, counter and output registers. Reset puts the PLL into reset and
  // holds every domain in reset.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_PLL_RST;
      rst_cnt_q     <= '0;
      stb_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      rel_cnt_q     <= '0;
      pll_reset_q   <= 1'b1;
      dom_rst_n_q   <= '0;
      ready_q       <= 1'b0;
      loss_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rst_cnt_q     <= rst_cnt_d;
      stb_cnt_q     <= stb_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      rel_cnt_q     <= rel_cnt_d;
      pll_reset_q   <= pll_reset_d;
      dom_rst_n_q   <= dom_rst_n_d;
      ready_q       <= ready_d;
      loss_cnt_q    <= loss_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign pll_reset     = pll_reset_q;
  assign domain_rst_n  = dom_rst_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign timeout_err   = timeout_err_q;
  assign state         = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb_pll_lock_supervisor
// Scoreboard bench. The stimulus process advances a behavioural model on
// every clock edge and queues the expected output snapshot. A monitor on the
// falling edge pops each snapshot and compares it with the DUT. Directed
// checks cover reset, lock-loss latency, timeout, glitch immunity, counter
// saturation and clear, and asynchronous reset. A random phase follows.

module tb_pll_lock_supervisor;

  localparam int N_DOMAINS          = 3;
  localparam int PLL_RST_CYCLES     = 4;
  localparam int LOCK_STABLE_CYCLES = 8;
  localparam int RELEASE_GAP        = 4;
  localparam int LOCK_TIMEOUT       = 64;
  localparam int CNT_W              = 2;
  localparam int CNT_MAX            = (1 << CNT_W) - 1;
  localparam int READY_LAT = PLL_RST_CYCLES + LOCK_STABLE_CYCLES + (N_DOMAINS - 1) * RELEASE_GAP + 1;

  logic                 refclk = 1'b0;
  logic                 rst_n;
  logic                 extlock;
  logic                 clr_cnt;
  logic                 pll_reset;
  logic [N_DOMAINS-1:0] domain_rst_n;
  logic                 ready;
  logic [CNT_W-1:0]     lock_loss_cnt;
  logic                 timeout_err;
  logic [1:0]           state;

  typedef struct packed {
    logic                 pll_reset;
    logic [N_DOMAINS-1:0] dom;
    logic                 ready;
    logic [CNT_W-1:0]     cnt;
    logic                 terr;
    logic [1:0]           st;
  } obs_t;

  typedef enum int {P_RST = 0, P_WAIT = 1, P_REL = 2, P_RUN = 3} phase_e;

  int   n_checks = 0;
  int   n_err    = 0;
  obs_t exp_q[$];

  pll_lock_supervisor #(
    .N_DOMAINS         (N_DOMAINS),
    .PLL_RST_CYCLES    (PLL_RST_CYCLES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES),
    .RELEASE_GAP       (RELEASE_GAP),
    .LOCK_TIMEOUT      (LOCK_TIMEOUT),
    .CNT_W             (CNT_W)
  ) dut (
    .refclk       (refclk),
    .rst_n        (rst_n),
    .extlock      (extlock),
    .clr_cnt      (clr_cnt),
    .pll_reset    (pll_reset),
    .domain_rst_n (domain_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_err  (timeout_err),
    .state        (state)
  );

  always #5 refclk = ~refclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // The phase plus the age within it determines all outputs. Lock as seen by
  // the supervisor is extlock delayed by two edges.
  phase_e m_phase;
  int     m_age;
  int     m_run;
  bit     m_p1, m_p2;
  int     m_cnt;
  bit     m_terr;

  task automatic model_reset();
    m_phase = P_RST;
    m_age   = 0;
    m_run   = 0;
    m_p1    = 1'b0;
    m_p2    = 1'b0;
    m_cnt   = 0;
    m_terr  = 1'b0;
  endtask

  task automatic model_edge(input bit l, input bit c);
    bit     ls;
    bit     loss;
    phase_e nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ls   = m_p2;
    m_p2 = m_p1;
    m_p1 = l;
    loss = ((m_phase == P_REL) || (m_phase == P_RUN)) && !ls;
    if (c) m_cnt = loss ? 1 : 0;
    else if (loss && (m_cnt < CNT_MAX)) m_cnt++;
    nxt = m_phase;
    case (m_phase)
      P_RST:  if (m_age + 1 >= PLL_RST_CYCLES) nxt = P_WAIT;
      P_WAIT: begin
        m_run = ls ? m_run + 1 : 0;
        if (m_run >= LOCK_STABLE_CYCLES) nxt = P_REL;
        else if (m_age + 1 >= LOCK_TIMEOUT) begin
          nxt    = P_RST;
          m_terr = 1'b1;
        end
      end
      P_REL: begin
        if (loss) nxt = P_RST;
        else if (m_age >= (N_DOMAINS - 1) * RELEASE_GAP) begin
          nxt    = P_RUN;
          m_terr = 1'b0;
        end
      end
      default: if (loss) nxt = P_RST;
    endcase
    if (nxt != m_phase) begin
      m_phase = nxt;
      m_age   = 0;
      m_run   = 0;
    end else begin
      m_age++;
    end
  endtask

  function automatic obs_t model_out();
    obs_t o;
    int   opened;
    o.pll_reset = (m_phase == P_RST);
    o.ready     = (m_phase == P_RUN);
    o.cnt       = CNT_W'(m_cnt);
    o.terr      = m_terr;
    o.st        = 2'(int'(m_phase));
    o.dom       = '0;
    if (m_phase == P_RUN) o.dom = '1;
    else if (m_phase == P_REL) begin
      opened = m_age / RELEASE_GAP + 1;
      if (opened > N_DOMAINS) opened = N_DOMAINS;
      o.dom = N_DOMAINS'((1 << opened) - 1);
    end
    return o;
  endfunction

  // One clock: inputs are applied now, the DUT samples them on the next
  // rising edge, and the model's expectation for that edge is queued.
  task automatic step(input bit l, input bit c);
    extlock = l;
    clr_cnt = c;
    @(posedge refclk);
    model_edge(l, c);
    exp_q.push_back(model_out());
    #2;
  endtask

  task automatic steps(input int n, input bit l);
    for (int i = 0; i < n; i++) step(l, 1'b0);
  endtask

  // Counts edges after reset release until ready rises, then compares the
  // count with the expected minimum latency.
  task automatic check_ready_latency(input string name);
    int k;
    k = 0;
    while (ready !== 1'b1 && k < 100) begin
      step(1'b1, 1'b0);
      k++;
    end
    check(name, 32'(k), 32'(READY_LAT));
  endtask

  // ---------------- monitor ----------------
  always @(negedge refclk) begin
    obs_t e;
    obs_t g;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = '{pll_reset, domain_rst_n, ready, lock_loss_cnt, timeout_err, state};
      n_checks++;
      if (g !== e) begin
        n_err++;
        $display("FAIL cycle_obs t=%0t got pll_reset=%b dom=%b ready=%b cnt=%0d terr=%b st=%0d expected pll_reset=%b dom=%b ready=%b cnt=%0d terr=%b st=%0d",
                 $time, g.pll_reset, g.dom, g.ready, g.cnt, g.terr, g.st,
                 e.pll_reset, e.dom, e.ready, e.cnt, e.terr, e.st);
      end
    end
  end

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_reset"}, 32'(pll_reset), 32'd1);
    check({tag, "_dom"},       32'(domain_rst_n), 32'd0);
    check({tag, "_ready"},     32'(ready), 32'd0);
    check({tag, "_cnt"},       32'(lock_loss_cnt), 32'd0);
    check({tag, "_terr"},      32'(timeout_err), 32'd0);
    check({tag, "_state"},     32'(state), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   guard;
    int   exp_cnt;
    model_reset();
    rst_n   = 1'b1;
    extlock = 1'b1;
    clr_cnt = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // Reset is applied before any clock edge, so these values come from the
    // asynchronous path.
    check_reset_values("reset");

    // 1: lock high from reset, measure time to ready.
    steps(2, 1'b1);
    rst_n = 1'b1;
    check_ready_latency("ready_latency");
    steps(3, 1'b1);

    // 2: one-cycle lock drop in RUN. Domains reset three edges later.
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("loss_dom",       32'(domain_rst_n), 32'd0);
    check("loss_ready",     32'(ready), 32'd0);
    check("loss_pll_reset", 32'(pll_reset), 32'd1);
    check("loss_cnt",       32'(lock_loss_cnt), 32'd1);
    steps(30, 1'b1);
    check("relock_ready", 32'(ready), 32'd1);

    // 3: permanent loss of lock. Repeated timeouts, then recovery.
    steps(180, 1'b0);
    check("timeout_flag", 32'(timeout_err), 32'd1);
    check("timeout_dom",  32'(domain_rst_n), 32'd0);
    steps(100, 1'b1);
    check("timeout_recover_ready", 32'(ready), 32'd1);
    check("timeout_recover_flag",  32'(timeout_err), 32'd0);

    // 4: lock toggling every 5 cycles never qualifies as stable.
    steps(3, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 16; i++) steps(5, i[0]);
    check("glitch_cnt", 32'(lock_loss_cnt), 32'd0);
    check("glitch_dom", 32'(domain_rst_n), 32'd0);
    steps(60, 1'b1);
    check("glitch_recover_ready", 32'(ready), 32'd1);

    // 5: five losses saturate a 2-bit counter. Then a clear that coincides
    // with a loss, followed by a plain clear.
    exp_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0);
      steps(30, 1'b1);
      if (exp_cnt < CNT_MAX) exp_cnt++;
      check("sat_cnt", 32'(lock_loss_cnt), 32'(exp_cnt));
    end
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check("clr_with_loss", 32'(lock_loss_cnt), 32'd1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    check("clr_plain", 32'(lock_loss_cnt), 32'd0);

    // 6: asynchronous reset in the middle of RELEASE.
    guard = 0;
    while (model_out().dom != N_DOMAINS'(3) && guard < 100) begin
      step(1'b1, 1'b0);
      guard++;
    end
    check("reach_release_011", 32'(guard < 100), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    check_reset_values("async");
    model_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    rst_n = 1'b1;
    check_ready_latency("ready_latency_after_async");

    // Random lock patterns with occasional counter clears.
    for (int i = 0; i < 1500;) begin
      bit lvl;
      int len;
      lvl = ($urandom_range(0, 99) < 80);
      if (lvl) len = $urandom_range(1, 40);
      else if ($urandom_range(0, 9) == 0) len = $urandom_range(60, 90);
      else len = $urandom_range(1, 6);
      for (int j = 0; j < len; j++) begin
        step(lvl, ($urandom_range(0, 29) == 0));
        i++;
      end
    end

    // Let the monitor consume what is still queued.
    guard = 0;
    while (exp_q.size() > 0 && guard < 10) begin
      @(posedge refclk);
      guard++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
